// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the asynchronous SRAM front end.
`timescale 1ns/1ps
package sram_ctrl_pkg;

  localparam int SRAM_AW = 16;
  localparam int SRAM_DW = 32;
  localparam int WAIT_W  = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SETUP  = 3'd1,
    WR_PULSE  = 3'd2,
    WR_HOLD   = 3'd3,
    RD_ACCESS = 3'd4,
    RD_DONE   = 3'd5
  } sram_ctrl_state_t;

  // States that present the one-cycle completion pulse.
  function automatic logic is_ack_state(input sram_ctrl_state_t st);
    return (st == WR_HOLD) || (st == RD_DONE);
  endfunction

endpackage

// File: rtl/sram_ctrl_props.sv
// Formal property set for sram_ctrl, bound onto the controller.
`timescale 1ns/1ps
`ifdef FORMAL
module sram_ctrl_props
  import sram_ctrl_pkg::*;
(
  input logic               CLK,
  input logic               N_RST,
  input logic               REQ,
  input logic               ACK,
  input logic               BUSY,
  input logic [SRAM_AW-1:0] SRAM_ADDR,
  input logic               SRAM_N_WE,
  input logic               SRAM_N_OE,
  input sram_ctrl_state_t   state_r
);

  a_strobe_excl: assert property (@(posedge CLK) SRAM_N_OE || SRAM_N_WE);

  a_ack_state: assert property (@(posedge CLK) disable iff (!N_RST)
    ACK |-> ((state_r == WR_HOLD) || (state_r == RD_DONE)));

  a_addr_idle: assert property (@(posedge CLK) disable iff (!N_RST)
    (!BUSY ##1 !BUSY) |-> $stable(SRAM_ADDR));

  m_req_stable: assume property (@(posedge CLK) disable iff (!N_RST)
    (REQ && !ACK) |=> REQ);

endmodule

bind sram_ctrl sram_ctrl_props u_props (.*);
`endif

// File: rtl/sram_ctrl.sv
// REQ/ACK to asynchronous SRAM strobe sequencer; every SRAM-side pin is a flop
// output so the strobes are glitch-free and N_OE/N_WE are never low together.
`timescale 1ns/1ps
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic               CLK,
  input  logic               N_RST,
  input  logic               REQ,
  input  logic               WE,
  input  logic [SRAM_AW-1:0] ADDR,
  input  logic [SRAM_DW-1:0] WDATA,
  output logic               ACK,
  output logic               BUSY,
  output logic [SRAM_DW-1:0] RDATA,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [SRAM_DW-1:0] SRAM_WDATA,
  output logic               SRAM_N_WE,
  output logic               SRAM_N_OE,
  input  logic [SRAM_DW-1:0] SRAM_RDATA
);

  if ((RD_WAIT < 32'd1) || (RD_WAIT > 32'd15)) begin : g_rd_wait_bad
    $error("sram_ctrl: RD_WAIT must be in 1..15");
  end
  if ((WR_WAIT < 32'd1) || (WR_WAIT > 32'd15)) begin : g_wr_wait_bad
    $error("sram_ctrl: WR_WAIT must be in 1..15");
  end

  localparam logic [WAIT_W-1:0] RD_LOAD = WAIT_W'(RD_WAIT - 32'd1);
  localparam logic [WAIT_W-1:0] WR_LOAD = WAIT_W'(WR_WAIT - 32'd1);

  sram_ctrl_state_t  state_r, state_nxt_s;
  logic [WAIT_W-1:0] cnt_r, cnt_nxt_s;
  logic              ack_r, busy_r, n_we_r, n_oe_r;
  logic [SRAM_AW-1:0] addr_r;
  logic [SRAM_DW-1:0] wdata_r, rdata_r;
  logic              accept_s, rd_capture_s;

  assign accept_s     = (state_r == IDLE) && REQ;
  assign rd_capture_s = (state_r == RD_ACCESS) && (cnt_r == {WAIT_W{1'b0}});

  // Next-state and wait-counter logic; the counter is loaded on entry to a timed state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (REQ) begin
          if (WE) begin
            state_nxt_s = WR_SETUP;
          end else begin
            state_nxt_s = RD_ACCESS;
            cnt_nxt_s   = RD_LOAD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_SETUP: begin
        state_nxt_s = WR_PULSE;
        cnt_nxt_s   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt_r == {WAIT_W{1'b0}}) begin
          state_nxt_s = WR_HOLD;
        end else begin
          cnt_nxt_s = cnt_r - {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      WR_HOLD:   state_nxt_s = IDLE;
      RD_ACCESS: begin
        if (cnt_r == {WAIT_W{1'b0}}) begin
          state_nxt_s = RD_DONE;
        end else begin
          cnt_nxt_s = cnt_r - {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      RD_DONE:   state_nxt_s = IDLE;
      default:   state_nxt_s = IDLE;
    endcase
  end

  // State register; strobes and status decoded from the next state so they leave flops.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_r <= IDLE;
      cnt_r   <= {WAIT_W{1'b0}};
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      n_we_r  <= 1'b1;
      n_oe_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ack_r   <= is_ack_state(state_nxt_s);
      busy_r  <= (state_nxt_s != IDLE);
      n_we_r  <= (state_nxt_s != WR_PULSE);
      n_oe_r  <= (state_nxt_s != RD_ACCESS);
    end
  end

  // Request latch and read-data capture on the closing edge of the access window.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      addr_r  <= {SRAM_AW{1'b0}};
      wdata_r <= {SRAM_DW{1'b0}};
      rdata_r <= {SRAM_DW{1'b0}};
    end else begin
      if (accept_s) begin
        addr_r  <= ADDR;
        wdata_r <= WDATA;
      end
      if (rd_capture_s) begin
        rdata_r <= SRAM_RDATA;
      end
    end
  end

  assign ACK        = ack_r;
  assign BUSY       = busy_r;
  assign RDATA      = rdata_r;
  assign SRAM_ADDR  = addr_r;
  assign SRAM_WDATA = wdata_r;
  assign SRAM_N_WE  = n_we_r;
  assign SRAM_N_OE  = n_oe_r;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench: default and wait-state instances, each on its own SRAM model.
`timescale 1ns/1ps
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        n_rst  [2];
  logic        req    [2];
  logic        we     [2];
  logic [15:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        ack    [2];
  logic        busy   [2];
  logic [31:0] rdata  [2];
  logic [15:0] s_addr [2];
  logic [31:0] s_wdata[2];
  logic [31:0] s_rdata[2];
  logic        s_n_we [2];
  logic        s_n_oe [2];

  logic [31:0] mem0 [65536];
  logic [31:0] mem1 [65536];

  int tests = 0;
  int fails = 0;
  logic [31:0] ref_mem [bit [16:0]];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  sram_ctrl dut0 (
    .CLK(clk), .N_RST(n_rst[0]), .REQ(req[0]), .WE(we[0]), .ADDR(addr[0]),
    .WDATA(wdata[0]), .ACK(ack[0]), .BUSY(busy[0]), .RDATA(rdata[0]),
    .SRAM_ADDR(s_addr[0]), .SRAM_WDATA(s_wdata[0]), .SRAM_N_WE(s_n_we[0]),
    .SRAM_N_OE(s_n_oe[0]), .SRAM_RDATA(s_rdata[0])
  );

  sram_ctrl #(.RD_WAIT(3), .WR_WAIT(2)) dut1 (
    .CLK(clk), .N_RST(n_rst[1]), .REQ(req[1]), .WE(we[1]), .ADDR(addr[1]),
    .WDATA(wdata[1]), .ACK(ack[1]), .BUSY(busy[1]), .RDATA(rdata[1]),
    .SRAM_ADDR(s_addr[1]), .SRAM_WDATA(s_wdata[1]), .SRAM_N_WE(s_n_we[1]),
    .SRAM_N_OE(s_n_oe[1]), .SRAM_RDATA(s_rdata[1])
  );

  // Asynchronous SRAM models: write on the N_WE falling edge, drive data while N_OE low.
  always @(negedge s_n_we[0]) mem0[s_addr[0]] = s_wdata[0];
  always @(negedge s_n_we[1]) mem1[s_addr[1]] = s_wdata[1];
  assign s_rdata[0] = s_n_oe[0] ? 32'h0 : mem0[s_addr[0]];
  assign s_rdata[1] = s_n_oe[1] ? 32'h0 : mem1[s_addr[1]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input int s, input logic [15:0] a);
    bit [16:0] k;
    k = {s[0], a};
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  // Strobe exclusion sampled every cycle, reset included.
  always @(negedge clk) begin
    check("strobe_excl0", {31'd0, s_n_oe[0] | s_n_we[0]}, 32'd1);
    check("strobe_excl1", {31'd0, s_n_oe[1] | s_n_we[1]}, 32'd1);
  end

  task automatic check_reset(input int s);
    check("rst_ack",   {31'd0, ack[s]},    32'd0);
    check("rst_busy",  {31'd0, busy[s]},   32'd0);
    check("rst_rdata", rdata[s],           32'd0);
    check("rst_addr",  {16'd0, s_addr[s]}, 32'd0);
    check("rst_wdata", s_wdata[s],         32'd0);
    check("rst_n_we",  {31'd0, s_n_we[s]}, 32'd1);
    check("rst_n_oe",  {31'd0, s_n_oe[s]}, 32'd1);
  endtask

  // One transaction: latency, strobe widths, address hold, data and the IDLE gap.
  task automatic txn(input int s, input logic w, input logic [15:0] a,
                     input logic [31:0] d, input bit keep, input bit glitch);
    int n, we_lo, oe_lo, lat, rw, ww;
    logic [31:0] exp_rd;
    rw = (s == 1) ? 3 : 1;
    ww = (s == 1) ? 2 : 1;
    lat = w ? 2 + ww : 1 + rw;
    exp_rd = w ? last_rd[s] : ref_rd(s, a);
    @(negedge clk);
    req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
    n = 0; we_lo = 0; oe_lo = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!s_n_we[s]) we_lo++;
      if (!s_n_oe[s]) oe_lo++;
      if (!ack[s]) check("busy_active", {31'd0, busy[s]}, 32'd1);
      check("addr_stable", {16'd0, s_addr[s]}, {16'd0, a});
      if (glitch && n == 2) begin
        addr[s] = 16'hFFFF;
        we[s] = ~w;
      end
    end while (!ack[s] && n < 40);
    check("latency", n, lat);
    check("n_we_low_cycles", we_lo, w ? ww : 0);
    check("n_oe_low_cycles", oe_lo, w ? 0 : rw);
    if (w) begin
      check("sram_wdata", s_wdata[s], d);
      ref_mem[{s[0], a}] = d;
    end else begin
      check("rdata", rdata[s], exp_rd);
      last_rd[s] = exp_rd;
    end
    if (!keep) req[s] = 1'b0;
    addr[s] = a; we[s] = w;
    @(posedge clk); #1;
    check("ack_single", {31'd0, ack[s]}, 32'd0);
    check("idle_gap", {31'd0, busy[s]}, 32'd0);
    check("rdata_hold", rdata[s], last_rd[s]);
    check("addr_idle", {16'd0, s_addr[s]}, {16'd0, a});
  endtask

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 65536; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    for (int s = 0; s < 2; s++) begin
      n_rst[s] = 1'b1; req[s] = 1'b0; we[s] = 1'b0;
      addr[s] = 16'h0; wdata[s] = 32'h0; last_rd[s] = 32'h0;
    end
    #1;
    n_rst[0] = 1'b0; n_rst[1] = 1'b0;
    #2;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    n_rst[0] = 1'b1; n_rst[1] = 1'b1;

    // Directed write then read at default timing, then with wait states.
    txn(0, 1'b1, 16'h0042, 32'hDEADBEEF, 1'b0, 1'b0);
    txn(0, 1'b0, 16'h0042, 32'h0, 1'b0, 1'b0);
    txn(1, 1'b1, 16'h0042, 32'hA5A55A5A, 1'b0, 1'b0);
    txn(1, 1'b0, 16'h0042, 32'h0, 1'b0, 1'b0);

    // Address/WE toggled during WR_PULSE must not leak into the SRAM.
    txn(0, 1'b1, 16'h0042, 32'hCAFEF00D, 1'b0, 1'b1);
    check("ffff_untouched", mem0[16'hFFFF], ref_rd(0, 16'hFFFF));
    txn(0, 1'b0, 16'h0042, 32'h0, 1'b0, 1'b0);
    txn(0, 1'b0, 16'hFFFF, 32'h0, 1'b0, 1'b0);

    // Back-to-back with REQ held high straight after each ACK.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        d = $urandom;
        txn(s, 1'b1, 16'(i), d, i < 3, 1'b0);
      end
      for (int i = 0; i < 4; i++) txn(s, 1'b0, 16'(i), 32'h0, i < 3, 1'b0);
    end

    // Reset during WR_PULSE: strobe releases at once and the word is committed.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0007; wdata[0] = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wr_pulse_low", {31'd0, s_n_we[0]}, 32'd0);
    n_rst[0] = 1'b0; req[0] = 1'b0;
    #1;
    check_reset(0);
    ref_mem[{1'b0, 16'h0007}] = 32'h12345678;
    last_rd[0] = 32'h0;
    @(negedge clk);
    n_rst[0] = 1'b1;
    txn(0, 1'b0, 16'h0007, 32'h0, 1'b0, 1'b0);

    // Reset during RD_ACCESS: RDATA clears and no ACK is produced.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0042;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rd_access_low", {31'd0, s_n_oe[1]}, 32'd0);
    n_rst[1] = 1'b0; req[1] = 1'b0;
    #1;
    check_reset(1);
    last_rd[1] = 32'h0;
    @(negedge clk);
    n_rst[1] = 1'b1;
    @(posedge clk); #1;
    check("no_ack_after_rd_reset", {31'd0, ack[1]}, 32'd0);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 60; i++) begin
      int s;
      logic w;
      s = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      txn(s, w, 16'($urandom_range(0, 15)), d, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
